// File: rtl/out_drain_writeback_pkg.sv
// Shared types and constants for the PE-array output drain / OUT SRAM writeback path.
package out_drain_writeback_pkg;

    localparam int DEF_OUT_SRAM_AWIDTH        = 10;
    localparam int DEF_OUT_SRAM_BWIDTH        = 1024;
    localparam int DEF_PE_ARRAY_NUM_ROWS      = 32;
    localparam int DEF_PE_ARRAY_NUM_ROWS_LOG2 = 5;
    localparam int DEF_PE_ARRAY_NUM_COLS      = 32;
    localparam int DEF_PE_ARRAY_NUM_COLS_LOG2 = 5;
    localparam int DEF_ACC_WIDTH              = 32;

    // Counts run 0..N inclusive, so they need one bit more than log2(N).
    function automatic int cnt_w(input int log2_n);
        return log2_n + 1;
    endfunction

    function automatic bit bwidth_ok(input int bwidth, input int cols, input int acc_w);
        return bwidth == cols * acc_w;
    endfunction

    localparam int ROW_CNT_W = cnt_w(DEF_PE_ARRAY_NUM_ROWS_LOG2);
    localparam int COL_CNT_W = cnt_w(DEF_PE_ARRAY_NUM_COLS_LOG2);
    localparam bit BWIDTH_OK = bwidth_ok(DEF_OUT_SRAM_BWIDTH, DEF_PE_ARRAY_NUM_COLS, DEF_ACC_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        LAST  = 2'd2
    } state_t;

endpackage

// File: rtl/out_drain_writeback_if.sv
// Control/data bundle between tile controller + PE array (master) and the drain block (slave).
interface out_drain_writeback_if
    import out_drain_writeback_pkg::*;
#(
    parameter int AW = DEF_OUT_SRAM_AWIDTH,
    parameter int BW = DEF_OUT_SRAM_BWIDTH,
    parameter int RW = ROW_CNT_W,
    parameter int NC = DEF_PE_ARRAY_NUM_COLS,
    parameter int CW = COL_CNT_W
);
    logic          FLUSH;
    logic          STALL;
    logic [AW-1:0] OUT_BASE_ADDR;
    logic [RW-1:0] VALID_ROWS;
    logic [CW-1:0] VALID_COLS;
    logic [BW-1:0] PE_ROW_DATA;
    logic          PE_SHIFT;
    logic          OUT_SRAM_WE;
    logic [AW-1:0] OUT_SRAM_ADDR;
    logic [BW-1:0] OUT_SRAM_WDATA;
    logic [NC-1:0] OUT_SRAM_WMASK;
    logic          BUSY;
    logic          DONE;

    modport master (
        output FLUSH, STALL, OUT_BASE_ADDR, VALID_ROWS, VALID_COLS, PE_ROW_DATA,
        input  PE_SHIFT, OUT_SRAM_WE, OUT_SRAM_ADDR, OUT_SRAM_WDATA, OUT_SRAM_WMASK, BUSY, DONE
    );

    modport slave (
        input  FLUSH, STALL, OUT_BASE_ADDR, VALID_ROWS, VALID_COLS, PE_ROW_DATA,
        output PE_SHIFT, OUT_SRAM_WE, OUT_SRAM_ADDR, OUT_SRAM_WDATA, OUT_SRAM_WMASK, BUSY, DONE
    );

endinterface

// File: rtl/out_drain_writeback_lane_mask_gen.sv
// Thermometer lane mask: lane i enabled when i < valid_cols; counts above NUM_COLS saturate.
module out_lane_mask_gen #(
    parameter int NUM_COLS  = 32,
    parameter int COL_CNT_W = 6
) (
    input  logic [COL_CNT_W-1:0] i_valid_cols,
    output logic [NUM_COLS-1:0]  o_mask
);

    for (genvar i = 0; i < NUM_COLS; i++) begin : g_lane
        assign o_mask[i] = (i_valid_cols > COL_CNT_W'(i));
    end

endmodule

// File: rtl/out_drain_writeback.sv
// Drains the PE array bottom-row-first on FLUSH and writes the valid rows/lanes into OUT SRAM.
//   state | meaning
//   IDLE  | waiting for FLUSH, config latched on accept
//   DRAIN | one row shifted per non-stalled cycle, write stage one cycle behind
//   LAST  | final (row 0) write stage, DONE pulse
module out_drain_writeback
    import out_drain_writeback_pkg::*;
#(
    parameter int OUT_SRAM_AWIDTH        = DEF_OUT_SRAM_AWIDTH,
    parameter int OUT_SRAM_BWIDTH        = DEF_OUT_SRAM_BWIDTH,
    parameter int PE_ARRAY_NUM_ROWS      = DEF_PE_ARRAY_NUM_ROWS,
    parameter int PE_ARRAY_NUM_ROWS_LOG2 = DEF_PE_ARRAY_NUM_ROWS_LOG2,
    parameter int PE_ARRAY_NUM_COLS      = DEF_PE_ARRAY_NUM_COLS,
    parameter int PE_ARRAY_NUM_COLS_LOG2 = DEF_PE_ARRAY_NUM_COLS_LOG2,
    parameter int ACC_WIDTH              = DEF_ACC_WIDTH
) (
    input  logic           CLK,
    input  logic           RSTn,
    out_drain_writeback_if.slave bus
);

    localparam int ROW_W = cnt_w(PE_ARRAY_NUM_ROWS_LOG2);
    localparam int COL_W = cnt_w(PE_ARRAY_NUM_COLS_LOG2);
    localparam int K_W   = PE_ARRAY_NUM_ROWS_LOG2;
    localparam logic [K_W-1:0] LAST_K = K_W'(PE_ARRAY_NUM_ROWS - 1);

    if (!bwidth_ok(OUT_SRAM_BWIDTH, PE_ARRAY_NUM_COLS, ACC_WIDTH)) begin : g_bwidth_chk
        $error("OUT_SRAM_BWIDTH must equal PE_ARRAY_NUM_COLS*ACC_WIDTH");
    end

    state_t                        r_state;
    state_t                        w_next_state;
    logic [K_W-1:0]                r_k;
    logic [OUT_SRAM_AWIDTH-1:0]    r_base;
    logic [ROW_W-1:0]              r_vrows;
    logic [COL_W-1:0]              r_vcols;
    logic                          r_we;
    logic [OUT_SRAM_AWIDTH-1:0]    r_addr;
    logic [OUT_SRAM_BWIDTH-1:0]    r_wdata;
    logic [PE_ARRAY_NUM_COLS-1:0]  r_wmask;
    logic                          r_done;
    logic                          w_shift;
    logic                          w_busy;
    logic [K_W-1:0]                w_row;
    logic                          w_write;
    logic [PE_ARRAY_NUM_COLS-1:0]  w_mask;

    out_lane_mask_gen #(
        .NUM_COLS  (PE_ARRAY_NUM_COLS),
        .COL_CNT_W (COL_W)
    ) u_mask (
        .i_valid_cols (r_vcols),
        .o_mask       (w_mask)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.FLUSH) w_next_state = DRAIN;
            DRAIN:   if (w_shift && (r_k == LAST_K)) w_next_state = LAST;
            LAST:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_shift = 1'b0;
        w_busy  = 1'b0;
        case (r_state)
            DRAIN: begin
                w_shift = !bus.STALL;
                w_busy  = 1'b1;
            end
            LAST:    w_busy = 1'b1;
            default: ;
        endcase
    end

    // Bottom row leaves first; row-count compare also saturates oversize VALID_ROWS.
    assign w_row   = LAST_K - r_k;
    assign w_write = (ROW_W'(w_row) < r_vrows) && (r_vcols != '0);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_k     <= '0;
            r_base  <= '0;
            r_vrows <= '0;
            r_vcols <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_done  <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            if ((r_state == IDLE) && bus.FLUSH) begin
                r_k     <= '0;
                r_base  <= bus.OUT_BASE_ADDR;
                r_vrows <= bus.VALID_ROWS;
                r_vcols <= bus.VALID_COLS;
            end
            if (w_shift) begin
                r_k <= r_k + K_W'(1);
                if (w_write) begin
                    r_we    <= 1'b1;
                    r_addr  <= r_base + OUT_SRAM_AWIDTH'(w_row);
                    r_wdata <= bus.PE_ROW_DATA;
                    r_wmask <= w_mask;
                end
                if (r_k == LAST_K) r_done <= 1'b1;
            end
        end
    end

    assign bus.PE_SHIFT       = w_shift;
    assign bus.BUSY           = w_busy;
    assign bus.OUT_SRAM_WE    = r_we;
    assign bus.OUT_SRAM_ADDR  = r_addr;
    assign bus.OUT_SRAM_WDATA = r_wdata;
    assign bus.OUT_SRAM_WMASK = r_wmask;
    assign bus.DONE           = r_done;

endmodule
